// File: rtl/regfile_write_arbiter_if.sv
// Writeback handshake and regfile-side bundle for the write arbiter.
// Master is the requester/stage side, slave is the arbiter.
interface regfile_write_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 16
);
   logic              valid0;
   logic [ADDR_W-1:0] rd0;
   logic [DATA_W-1:0] data0;
   logic              ready0;
   logic              valid1;
   logic [ADDR_W-1:0] rd1;
   logic [DATA_W-1:0] data1;
   logic              ready1;
   logic [ADDR_W-1:0] rs0;
   logic [ADDR_W-1:0] rs1;
   logic              regWrite;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] dataWrite;
   logic              busy0;
   logic              busy1;
   logic [CNT_W-1:0]  writeCount;

   modport master (
      output valid0, rd0, data0,
      output valid1, rd1, data1,
      output rs0, rs1,
      input  ready0, ready1,
      input  regWrite, rd, dataWrite,
      input  busy0, busy1, writeCount
   );

   modport slave (
      input  valid0, rd0, data0,
      input  valid1, rd1, data1,
      input  rs0, rs1,
      output ready0, ready1,
      output regWrite, rd, dataWrite,
      output busy0, busy1, writeCount
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU and load
// writeback, with registered write drive and in-flight operand flags.
module regfile_write_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   regfile_write_arbiter_if.slave  bus
);
   logic              grant0;
   logic              grant1;
   logic              last_grant;
   logic              we_next;
   logic              reg_write;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  count;

   // last_grant=1 means req1 won last, so req0 wins the next tie
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!RST) begin
         unique case (1'b1)
            (bus.valid0 && bus.valid1): begin
               grant0 = last_grant;
               grant1 = !last_grant;
            end
            (bus.valid0 && !bus.valid1): grant0 = 1'b1;
            (!bus.valid0 && bus.valid1): grant1 = 1'b1;
            default: ;
         endcase
      end
   end

   assign we_next = (grant0 && (bus.rd0 != '0)) ||
                    (grant1 && (bus.rd1 != '0));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         reg_write  <= 1'b0;
         rd_q       <= '0;
         data_q     <= '0;
         count      <= '0;
         last_grant <= 1'b1;
      end else begin
         reg_write <= we_next;
         if (grant0) begin
            rd_q       <= bus.rd0;
            data_q     <= bus.data0;
            last_grant <= 1'b0;
         end else if (grant1) begin
            rd_q       <= bus.rd1;
            data_q     <= bus.data1;
            last_grant <= 1'b1;
         end
         if (we_next)
            count <= count + 1'b1;
      end
   end

   assign bus.ready0     = grant0;
   assign bus.ready1     = grant1;
   assign bus.regWrite   = reg_write;
   assign bus.rd         = rd_q;
   assign bus.dataWrite  = data_q;
   assign bus.writeCount = count;
   assign bus.busy0      = reg_write && (rd_q == bus.rs0) && (rd_q != '0);
   assign bus.busy1      = reg_write && (rd_q == bus.rs1) && (rd_q != '0);
endmodule
